// File: rtl/abc_sweep_checker.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | abc_sweep_checker                                                        |
// | Drives all 8 {A,B,C} vectors into F = A(B+C), captures F per vector and  |
// | compares the captured truth table against a golden table.                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module abc_sweep_checker #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] EXPECTED      = 8'b11100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       F,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth_table,
  output logic [7:0] mismatch_mask,
  output logic [3:0] err_count
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range_check
      $error("abc_sweep_checker: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] abc_q, abc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] tt_q, tt_d;
  logic [7:0] mm_q, mm_d;
  logic [3:0] ec_q, ec_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    mm_d    = mm_q;
    ec_d    = ec_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          tt_d    = 8'h00;
          mm_d    = 8'h00;
          ec_d    = 4'd0;
          pass_d  = 1'b0;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        tt_d[idx_q] = F;
        if (F != EXPECTED[idx_q]) begin
          mm_d[idx_q] = 1'b1;
          ec_d        = ec_q + 4'd1;
        end
        if (idx_q == 3'd7) begin
          // Uses mm_d so the final vector's verdict is included.
          pass_d  = (mm_d == 8'h00);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = 4'd0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with state_q.
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    case (state_d)
      SETTLE, SAMPLE: abc_d = idx_d;
      DONE:           abc_d = 3'b111;
      default:        abc_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      abc_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tt_q    <= 8'h00;
      mm_q    <= 8'h00;
      ec_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
      ec_q    <= ec_d;
    end
  end

  assign A             = abc_q[2];
  assign B             = abc_q[1];
  assign C             = abc_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign truth_table   = tt_q;
  assign mismatch_mask = mm_q;
  assign err_count     = ec_q;

endmodule
`default_nettype wire

// File: tb/tb_abc_sweep_checker.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for abc_sweep_checker: two instances (SETTLE_CYCLES 2 and 1)
// driven by selectable function-block models.
module tb_abc_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mode  = 0;  // 0 correct, 1 A|(B&C), 2 stuck-0, 3 stuck-1

  logic       rst1, start1, f1, a1, b1, c1, busy1, done1, pass1;
  logic [7:0] tt1, mm1;
  logic [3:0] ec1;
  logic       rst2, start2, f2, a2, b2, c2, busy2, done2, pass2;
  logic [7:0] tt2, mm2;
  logic [3:0] ec2;

  logic [2:0] abc_log [0:255];

  always_comb begin
    case (mode)
      1:       f1 = a1 | (b1 & c1);
      2:       f1 = 1'b0;
      3:       f1 = 1'b1;
      default: f1 = a1 & (b1 | c1);
    endcase
  end
  assign f2 = a2 & (b2 | c2);

  abc_sweep_checker #(.SETTLE_CYCLES(2), .EXPECTED(8'b11100000)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .F(f1),
    .A(a1), .B(b1), .C(c1), .busy(busy1), .done(done1), .pass(pass1),
    .truth_table(tt1), .mismatch_mask(mm1), .err_count(ec1)
  );

  abc_sweep_checker #(.SETTLE_CYCLES(1), .EXPECTED(8'b11100000)) u_dut2 (
    .clk(clk), .rst(rst2), .start(start2), .F(f2),
    .A(a2), .B(b2), .C(c2), .busy(busy2), .done(done2), .pass(pass2),
    .truth_table(tt2), .mismatch_mask(mm2), .err_count(ec2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic dn(input int d);
    return (d == 1) ? done1 : done2;
  endfunction
  function automatic logic bz(input int d);
    return (d == 1) ? busy1 : busy2;
  endfunction
  function automatic logic [2:0] ab(input int d);
    return (d == 1) ? {a1, b1, c1} : {a2, b2, c2};
  endfunction
  function automatic logic [25:0] all_out(input int d);
    if (d == 1) return {a1, b1, c1, busy1, done1, pass1, tt1, mm1, ec1};
    return {a2, b2, c2, busy2, done2, pass2, tt2, mm2, ec2};
  endfunction

  // Start a sweep, optionally re-pulse start at loop counts r1/r2, count cycles to done.
  task automatic run(input int d, input int r1, input int r2, input bit clr,
                     output int lat, output int busyc);
    if (d == 1) start1 = 1'b1; else start2 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
    if (clr) begin
      chk("restart_cleared", all_out(d), {3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0});
    end
    lat   = 0;
    busyc = 0;
    while (!dn(d) && lat < 200) begin
      if (bz(d)) busyc++;
      abc_log[lat] = ab(d);
      if ((lat == r1) || (lat == r2)) begin
        if (d == 1) start1 = 1'b1; else start2 = 1'b1;
      end
      tick();
      start1 = 1'b0;
      start2 = 1'b0;
      lat++;
    end
  endtask

  task automatic chk_res(input int d, input logic [7:0] tt, input logic [7:0] mm,
                         input logic [3:0] ec, input logic ps);
    chk("truth_table", (d == 1) ? tt1 : tt2, tt);
    chk("mismatch_mask", (d == 1) ? mm1 : mm2, mm);
    chk("err_count", (d == 1) ? ec1 : ec2, ec);
    chk("pass", (d == 1) ? pass1 : pass2, ps);
    chk("done_busy_abc", {dn(d), bz(d), ab(d)}, {1'b1, 1'b0, 3'b111});
  endtask

  int lat, busyc;

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
    tick(); tick();
    chk("reset_dut1", all_out(1), 26'd0);
    chk("reset_dut2", all_out(2), 26'd0);
    rst1 = 1'b0; rst2 = 1'b0;
    tick();
    chk("idle_dut1", all_out(1), 26'd0);

    // Correct model
    mode = 0;
    run(1, -1, -1, 1'b0, lat, busyc);
    chk("t1_latency", lat, 24);
    chk("t1_busy_cycles", busyc, 24);
    chk("t1_abc_first", abc_log[0], 3'd0);
    chk("t1_abc_mid", abc_log[13], 3'd4);
    chk("t1_abc_last", abc_log[23], 3'd7);
    chk_res(1, 8'hE0, 8'h00, 4'd0, 1'b1);

    // Faulty model A|(B&C)
    mode = 1;
    run(1, -1, -1, 1'b1, lat, busyc);
    chk("t2_latency", lat, 24);
    chk_res(1, 8'hF8, 8'h18, 4'd2, 1'b0);

    // Stuck-at faults
    mode = 2;
    run(1, -1, -1, 1'b1, lat, busyc);
    chk_res(1, 8'h00, 8'hE0, 4'd3, 1'b0);
    mode = 3;
    run(1, -1, -1, 1'b1, lat, busyc);
    chk_res(1, 8'hFF, 8'h1F, 4'd5, 1'b0);

    // start re-pulsed mid-sweep is ignored
    mode = 0;
    run(1, 5, 17, 1'b1, lat, busyc);
    chk("t4_latency", lat, 24);
    chk("t4_busy_cycles", busyc, 24);
    chk_res(1, 8'hE0, 8'h00, 4'd0, 1'b1);

    // Reset mid-sweep
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (10) tick();
    chk("t5_busy_before_rst", busy1, 1'b1);
    rst1 = 1'b1;
    #1;
    chk("t5_async_reset", all_out(1), 26'd0);
    tick();
    rst1 = 1'b0;
    tick();
    tick();
    chk("t5_idle_after_rst", all_out(1), 26'd0);
    run(1, -1, -1, 1'b0, lat, busyc);
    chk("t5_latency", lat, 24);
    chk_res(1, 8'hE0, 8'h00, 4'd0, 1'b1);

    // SETTLE_CYCLES=1 instance, then restart from DONE
    run(2, -1, -1, 1'b0, lat, busyc);
    chk("t6_latency_first", lat, 16);
    chk_res(2, 8'hE0, 8'h00, 4'd0, 1'b1);
    run(2, -1, -1, 1'b1, lat, busyc);
    chk("t6_latency_second", lat, 16);
    chk("t6_busy_cycles", busyc, 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t6_abc_step%0d", k), abc_log[k], 32'(k / 2));
    end
    chk_res(2, 8'hE0, 8'h00, 4'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
